// File: rtl/serializer_pkg.sv
// Shared types and constants for the byte serializer and its bit counter.
package serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/serializer_bit_counter.sv
// Loadable up-counter with clear and enable; tc flags the last data bit (WIDTH-1).
module serializer_bit_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter: valid/ready byte load in, one bit per transfer out.
// Optional trailing even-parity bit when SERIALIZER_PARITY_EN is defined.
module byte_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_q;
  logic             dir_q;
  logic             xfer;
  logic             load_fire;
  logic             cnt_tc;
  logic             cnt_en;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q;
`endif

  assign sout_valid = (state != IDLE);
  assign busy       = (state != IDLE);
  assign xfer       = sout_valid && sout_ready;

`ifdef SERIALIZER_PARITY_EN
  assign sout_last  = (state == PARITY);
`else
  assign sout_last  = (state == SHIFT) && cnt_tc;
`endif

  // A new frame may be loaded in the same cycle the final bit leaves.
  assign load_ready = (state == IDLE) || (xfer && sout_last);
  assign load_fire  = load_valid && load_ready;

  // Holding the counter at its terminal value keeps it from wrapping mid-frame.
  assign cnt_en     = xfer && (state == SHIFT) && !cnt_tc;

  serializer_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_fire),
    .load       (1'b0),
    .load_value ('0),
    .enable     (cnt_en),
    .tc         (cnt_tc)
  );

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    sout       = 1'b0;
    case (state)
      IDLE: begin
        if (load_fire) state_next = SHIFT;
      end
      SHIFT: begin
        sout = (dir_q == DIR_LSB_FIRST) ? shift_q[0] : shift_q[WIDTH-1];
        if (xfer && cnt_tc) begin
`ifdef SERIALIZER_PARITY_EN
          state_next = PARITY;
`else
          state_next = load_fire ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        sout = parity_q;
        if (xfer) state_next = load_fire ? SHIFT : IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      dir_q    <= DIR_MSB_FIRST;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (load_fire) begin
      shift_q  <= din;
      dir_q    <= dir;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= ^din;
`endif
    end else if (xfer && (state == SHIFT)) begin
      if (dir_q == DIR_LSB_FIRST) shift_q <= {1'b0, shift_q[WIDTH-1:1]};
      else                        shift_q <= {shift_q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboard bench for byte_serializer: accepted loads push the expected bit
// stream into a queue; a negedge monitor pops and compares each transfer.
module tb_byte_serializer;
  import serializer_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         dir;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         sout_last;
  logic         busy;

  byte_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dir        (dir),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_xfer   = 0;
  bit   mon_en   = 1'b0;
  bit   exp_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is just the din bits in the requested order,
  // optionally followed by the even parity of din.
  function automatic void push_frame(input logic [W-1:0] d, input logic lsb_first);
    exp_t e;
    int   pos;
    for (int i = 0; i < W; i++) begin
      pos    = lsb_first ? i : (W - 1 - i);
      e.b    = d[pos];
      e.last = (i == W - 1);
`ifdef SERIALIZER_PARITY_EN
      e.last = 1'b0;
`endif
      q.push_back(e);
    end
`ifdef SERIALIZER_PARITY_EN
    e.b    = ($countones(d) % 2) == 1;
    e.last = 1'b1;
    q.push_back(e);
`endif
  endfunction

  // Scoreboard push side: every load the DUT accepts adds one expected frame.
  always @(posedge clk) begin
    if (rst === 1'b1) q.delete();
    else if (load_valid === 1'b1 && load_ready === 1'b1) push_frame(din, dir);
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_valid = (q.size() != 0);
      check("sout_valid", sout_valid, exp_valid);
      check("busy", busy, exp_valid);
      check("load_ready", load_ready, !exp_valid || (q.size() == 1 && sout_ready));
      if (exp_valid && sout_valid === 1'b1) begin
        check("sout", sout, q[0].b);
        check("sout_last", sout_last, q[0].last);
        if (sout_ready) begin
          q.delete(0);
          n_xfer++;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic r);
    bit acc;
    bit got;
    got        = 1'b0;
    load_valid = 1'b1;
    din        = d;
    dir        = r;
    for (int i = 0; i < 64; i++) begin
      acc = load_ready;
      cycle();
      if (acc) begin
        got = 1'b1;
        break;
      end
    end
    load_valid = 1'b0;
    check("load accepted", got, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    check("drain", q.size(), 0);
  endtask

  int base;

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    din        = '0;
    dir        = DIR_MSB_FIRST;
    sout_ready = 1'b0;
    repeat (2) cycle();

    check("reset load_ready", load_ready, 1'b1);
    check("reset sout", sout, 1'b0);
    check("reset sout_valid", sout_valid, 1'b0);
    check("reset sout_last", sout_last, 1'b0);
    check("reset busy", busy, 1'b0);
    rst        = 1'b0;
    mon_en     = 1'b1;
    sout_ready = 1'b1;

    // C4 MSB first, then LSB first with a mid-frame load_ready probe
    base = n_xfer;
    send(8'hC4, DIR_MSB_FIRST);
    wait_idle();
    cycle();
    check("frame C4 msb transfers", n_xfer - base, q.size() + W
`ifdef SERIALIZER_PARITY_EN
      + 1
`endif
    );
    send(8'hC4, DIR_LSB_FIRST);
    cycle();
    cycle();
    check("load_ready mid-frame", load_ready, 1'b0);
    wait_idle();
    cycle();

    // Stall after the second bit: sout must hold the third bit (0)
    base = n_xfer;
    send(8'hC4, DIR_MSB_FIRST);
    cycle();
    cycle();
    sout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall sout", sout, 1'b0);
      check("stall sout_valid", sout_valid, 1'b1);
    end
    sout_ready = 1'b1;
    wait_idle();
    cycle();
    check("stall frame transfers", n_xfer - base, W
`ifdef SERIALIZER_PARITY_EN
      + 1
`endif
    );

    // Back-to-back frames with load_valid held: monitor flags any gap
    base = n_xfer;
    send(8'hFF, DIR_MSB_FIRST);
    send(8'h00, DIR_MSB_FIRST);
    wait_idle();
    cycle();
    check("back-to-back transfers", n_xfer - base, 2 * (W
`ifdef SERIALIZER_PARITY_EN
      + 1
`endif
    ));

    // Reset during the 4th bit aborts the frame
    send(8'hA5, DIR_MSB_FIRST);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort sout_valid", sout_valid, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort load_ready", load_ready, 1'b1);
    send(8'h01, DIR_LSB_FIRST);
    wait_idle();
    cycle();

    // Reset wins over a simultaneous load
    rst        = 1'b1;
    load_valid = 1'b1;
    din        = 8'hFF;
    cycle();
    rst        = 1'b0;
    load_valid = 1'b0;
    check("rst over load sout_valid", sout_valid, 1'b0);
    check("rst over load busy", busy, 1'b0);

    // Randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom % 2) == 1;
      din        = W'($urandom);
      dir        = ($urandom % 2) == 1;
      sout_ready = ($urandom % 4) != 0;
      rst        = ($urandom % 80) == 0;
      cycle();
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    sout_ready = 1'b1;
    wait_idle();
    cycle();
    check("final idle busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Parallel-to-serial transmitter for the ALU datapath. It accepts a byte over a valid/ready load handshake and drives it out one bit per accepted transfer on a serial valid/ready stream, MSB-first or LSB-first. It is the transmit end for the serial byte shifter, which captures a stream by inserting one bit per step at either end of a byte. It sits between the byte-wide ALU result (logic or arithmetic unit output) and any serial link that feeds a shifter-based receiver.

## Interface
Parameters:
- WIDTH, 8, data bits per frame; legal range 2..16.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  byte to transmit; sampled only on load acceptance.
- dir  input  1  bit order, sampled with din: 0 = MSB first, 1 = LSB first.
- load_valid  input  1  din/dir are valid.
- load_ready  output  1  block can accept a load this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout is valid.
- sout_ready  input  1  downstream consumes sout this cycle.
- sout_last  output  1  sout is the final bit of the frame.
- busy  output  1  a frame is in progress.

## Operation
- States: IDLE, SHIFT, and PARITY when PARITY is compiled in (see Configuration).
- IDLE:
  - load_ready=1, sout_valid=0.
  - On load_valid&&load_ready: capture din into the shift register and dir into the order flag, clear the bit counter, go to SHIFT.
- SHIFT:
  - sout_valid=1.
  - sout = reg[WIDTH-1] when dir=0, reg[0] when dir=1.
  - On sout_valid&&sout_ready:
    - shift left (dir=0) or right (dir=1), filling the vacated end with 0;
    - increment the counter.
  - With no sout_ready, the register, counter and sout hold unchanged.
- Last data bit (counter==WIDTH-1):
  - sout_last=1 without PARITY.
  - On transfer go to IDLE, or reload directly (see back-to-back).
  - With PARITY, go to PARITY instead.
- Back-to-back:
  - load_ready=1 in IDLE and also in the final-bit cycle (sout_valid&&sout_ready&&sout_last).
  - A load accepted in that cycle starts the next frame with no idle gap.
- busy=1 in SHIFT/PARITY, 0 in IDLE.
- A load_valid in any other state is ignored; load_ready=0 there. din changes after acceptance have no effect.

## Timing
- Reset values: load_ready=1, sout=0, sout_valid=0, sout_last=0, busy=0, state IDLE, register and counter 0.
- rst asserted mid-frame aborts the frame. Outputs take reset values on the next edge, and the partial frame is never resumed.
- rst has priority over a simultaneous load.
- Latency: load accepted at edge N gives the first bit valid from cycle N+1.
- Frame length with sout_ready held high: WIDTH cycles, or WIDTH+1 with PARITY.
- Counter width: $clog2(WIDTH).
- The counter never wraps inside a frame; it is cleared on every load.
- Outputs are registered, with no combinational path from sout_ready to sout. The exceptions are load_ready, which depends on sout_ready in the final-bit cycle, and sout_last, which is decoded from the state and counter.

## Configuration
- SERIALIZER_PARITY_EN
  - Defined: after the last data bit, one extra PARITY cycle drives sout = even parity (XOR of all din bits captured at load) with sout_last=1; the handshake is identical. The data-bit cycle has sout_last=0.
  - Undefined: the PARITY state and its logic are absent; the frame is exactly WIDTH bits.

## Structure
- Shared package serializer_pkg:
  - state enum (IDLE, SHIFT, PARITY);
  - DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1;
  - default frame width 8.
- One sub-module, serializer_bit_counter:
  - loadable up-counter with clear and enable;
  - terminal-count output at WIDTH-1.
- The FSM, shift register and parity XOR live in byte_serializer.

## Test plan
- Reset then load din=8'hC4, dir=0, sout_ready=1 -> sout 1,1,0,0,0,1,0,0 over 8 cycles; sout_last only on the 8th; busy drops the cycle after.
- Load din=8'hC4, dir=1 -> sout 0,0,1,0,0,0,1,1; load_ready=0 mid-frame.
- 8'hC4, dir=0, sout_ready low for 3 cycles after the 2nd bit -> sout holds 0, sout_valid stays 1, the frame completes with 8 transfers total.
- Back-to-back: 8'hFF then 8'h00, load_valid held -> 16 contiguous valid bits (eight 1s, eight 0s) with no gap.
- rst pulsed during the 4th bit of 8'hA5 -> next cycle sout_valid=0, busy=0, load_ready=1; a new load of 8'h01 dir=1 emits 1 then seven 0s.
- With SERIALIZER_PARITY_EN, 8'hC4, dir=0 -> 9 bits, 9th = 1, sout_last only on the 9th.
